// File: rtl/mips_mc_ctrl_pkg.sv
// mips_mc_ctrl_pkg: opcode/funct constants, state and datapath select encodings
package mips_mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_WB_R     = 4'd8,
      S_EXEC_I   = 4'd9,
      S_WB_I     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_HALT     = 4'd13
   } state_t;

   localparam logic [1:0] ALU_ADD      = 2'd0;
   localparam logic [1:0] ALU_SUB      = 2'd1;
   localparam logic [1:0] ALU_OR       = 2'd2;

   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_4       = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH  = 2'd3;

   localparam logic [1:0] EXT_SIGN     = 2'd0;
   localparam logic [1:0] EXT_ZERO     = 2'd1;
   localparam logic [1:0] EXT_LUI      = 2'd2;

   localparam logic [1:0] DST_RT       = 2'd0;
   localparam logic [1:0] DST_RD       = 2'd1;
   localparam logic [1:0] DST_RA       = 2'd2;

   localparam logic [1:0] M2R_ALU      = 2'd0;
   localparam logic [1:0] M2R_MDR      = 2'd1;
   localparam logic [1:0] M2R_PC       = 2'd2;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_JR     = 2'd3;

   // one-hot instruction class; ill is set when nothing else matches
   typedef struct packed {
      logic r_addu;
      logic r_subu;
      logic jr;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic ill;
   } cls_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: IR fields and ALU flag in, datapath selects and enables out
interface mips_mc_ctrl_if;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_wr;
   logic       ir_wr;
   logic       reg_wr;
   logic       mem_wr;
   logic       i_or_d;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] ext_op;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic [1:0] pc_src;
   logic       instr_done;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero,
      output pc_wr, ir_wr, reg_wr, mem_wr, i_or_d, alu_src_a, alu_src_b, alu_op,
             ext_op, reg_dst, mem_to_reg, pc_src, instr_done, illegal, state
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_wr, ir_wr, reg_wr, mem_wr, i_or_d, alu_src_a, alu_src_b, alu_op,
             ext_op, reg_dst, mem_to_reg, pc_src, instr_done, illegal, state
   );

endinterface

// File: rtl/mips_mc_ctrl_decode.sv
// mips_mc_ctrl_decode: opcode/funct to one-hot instruction class
module mips_mc_ctrl_decode
   import mips_mc_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output cls_t       o_cls
);

   logic       w_rtype;
   logic [9:0] w_hit;

   assign w_rtype = i_opcode == OP_RTYPE;
   assign w_hit   = {w_rtype && i_funct == FN_ADDU,
                     w_rtype && i_funct == FN_SUBU,
                     w_rtype && i_funct == FN_JR,
                     i_opcode == OP_ORI,
                     i_opcode == OP_LUI,
                     i_opcode == OP_LW,
                     i_opcode == OP_SW,
                     i_opcode == OP_BEQ,
                     i_opcode == OP_J,
                     i_opcode == OP_JAL};
   assign o_cls   = {w_hit, ~|w_hit};

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM driving datapath selects and write enables
module mips_mc_ctrl
   import mips_mc_ctrl_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
)
(
   input  logic           clk,
   input  logic           reset,
   mips_mc_ctrl_if.master bus
);

   state_t r_state;
   state_t w_next;
   cls_t   w_cls;

   mips_mc_ctrl_decode u_decode (
      .i_opcode (bus.opcode),
      .i_funct  (bus.funct),
      .o_cls    (w_cls)
   );

   // state register; async reset drops to IDLE so every enable falls at once
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;

   // next state: dispatch in DECODE, class-dependent split in MEM_ADDR, HALT is sticky
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = S_DECODE;
         S_DECODE:   w_next = (w_cls.lw || w_cls.sw)              ? S_MEM_ADDR :
                              (w_cls.r_addu || w_cls.r_subu)      ? S_EXEC_R   :
                              (w_cls.ori || w_cls.lui)            ? S_EXEC_I   :
                              w_cls.beq                           ? S_BRANCH   :
                              (w_cls.j || w_cls.jal || w_cls.jr)  ? S_JUMP     :
                              HALT_ON_ILLEGAL                     ? S_HALT     : S_FETCH;
         S_MEM_ADDR: w_next = w_cls.lw ? S_MEM_RD : w_cls.sw ? S_MEM_WR : S_FETCH;
         S_MEM_RD:   w_next = S_MEM_WB;
         S_EXEC_R:   w_next = S_WB_R;
         S_EXEC_I:   w_next = S_WB_I;
         S_HALT:     w_next = S_HALT;
         default:    w_next = S_FETCH;
      endcase
   end

   // outputs are a pure function of state and the IR/zero inputs; zero only matters in BRANCH
   always_comb begin
      bus.pc_wr      = 1'b0;
      bus.ir_wr      = 1'b0;
      bus.reg_wr     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = SRCB_B;
      bus.alu_op     = ALU_ADD;
      bus.ext_op     = EXT_SIGN;
      bus.reg_dst    = DST_RT;
      bus.mem_to_reg = M2R_ALU;
      bus.pc_src     = PCSRC_ALU;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            bus.ir_wr     = 1'b1;
            bus.pc_wr     = 1'b1;
            bus.alu_src_b = SRCB_4;
         end
         S_DECODE: begin
            bus.alu_src_b = SRCB_IMM_SH;
            bus.illegal   = w_cls.ill;
         end
         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: bus.i_or_d = 1'b1;
         S_MEM_WB: begin
            bus.mem_to_reg = M2R_MDR;
            bus.reg_wr     = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            bus.i_or_d     = 1'b1;
            bus.mem_wr     = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_EXEC_R: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = w_cls.r_subu ? ALU_SUB : ALU_ADD;
         end
         S_WB_R: begin
            bus.reg_dst    = DST_RD;
            bus.reg_wr     = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_EXEC_I: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_op    = ALU_OR;
            bus.ext_op    = w_cls.lui ? EXT_LUI : EXT_ZERO;
         end
         S_WB_I: begin
            bus.reg_wr     = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_op     = ALU_SUB;
            bus.pc_src     = PCSRC_ALUOUT;
            bus.pc_wr      = bus.zero;
            bus.instr_done = 1'b1;
         end
         S_JUMP: begin
            bus.pc_wr      = 1'b1;
            bus.pc_src     = w_cls.jr ? PCSRC_JR : PCSRC_JUMP;
            bus.reg_wr     = w_cls.jal;
            bus.reg_dst    = w_cls.jal ? DST_RA : DST_RT;
            bus.mem_to_reg = w_cls.jal ? M2R_PC : M2R_ALU;
            bus.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.state = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scoreboard bench for the control FSM, one DUT per illegal-opcode policy
module tb_mips_mc_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, rw, mw, iod, sa;
      logic [1:0] sb, aop, eop, rd, m2r, ps;
      logic       dn, il;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic halted;

   exp_t       q_e[$];
   logic [3:0] q_h[$];
   string      q_n[$];

   exp_t E_I, E_F, E_D, E_DI, E_XADD, E_XSUB, E_WBR, E_MA, E_MR, E_MWB, E_MWR;
   exp_t E_XORI, E_XLUI, E_WBI, E_BRT, E_BRN, E_J, E_JAL, E_JR;

   mips_mc_ctrl_if if0 ();
   mips_mc_ctrl_if if1 ();

   assign if1.opcode = if0.opcode;
   assign if1.funct  = if0.funct;
   assign if1.zero   = if0.zero;

   mips_mc_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   mips_mc_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t e(input int st, pcw, irw, rw, mw, iod, sa, sb, aop, eop, rd, m2r, ps, dn, il);
      exp_t r;
      r.st  = 4'(st);
      r.pcw = 1'(pcw);
      r.irw = 1'(irw);
      r.rw  = 1'(rw);
      r.mw  = 1'(mw);
      r.iod = 1'(iod);
      r.sa  = 1'(sa);
      r.sb  = 2'(sb);
      r.aop = 2'(aop);
      r.eop = 2'(eop);
      r.rd  = 2'(rd);
      r.m2r = 2'(m2r);
      r.ps  = 2'(ps);
      r.dn  = 1'(dn);
      r.il  = 1'(il);
      return r;
   endfunction

   task automatic step(input string n, input logic rs, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input exp_t x);
      @(posedge clk);
      #1;
      reset      = rs;
      if0.opcode = op;
      if0.funct  = fn;
      if0.zero   = z;
      if (rs) halted = 1'b0;
      q_e.push_back(x);
      q_h.push_back(halted ? 4'd13 : x.st);
      q_n.push_back(n);
   endtask

   task automatic ins(input string n, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int k, input exp_t a, input exp_t b, input exp_t c);
      step({n, "_fetch"}, 1'b0, op, fn, z, E_F);
      step({n, "_decode"}, 1'b0, op, fn, z, E_D);
      step({n, "_s1"}, 1'b0, op, fn, z, a);
      if (k > 1) step({n, "_s2"}, 1'b0, op, fn, z, b);
      if (k > 2) step({n, "_s3"}, 1'b0, op, fn, z, c);
   endtask

   // monitor: every cycle with a pending expectation, compare both DUTs at the falling edge
   initial begin
      exp_t       x;
      exp_t       a;
      logic [3:0] h;
      string      n;
      forever begin
         @(negedge clk);
         if (q_e.size() != 0) begin
            x = q_e.pop_front();
            h = q_h.pop_front();
            n = q_n.pop_front();
            a = {if0.state, if0.pc_wr, if0.ir_wr, if0.reg_wr, if0.mem_wr, if0.i_or_d, if0.alu_src_a,
                 if0.alu_src_b, if0.alu_op, if0.ext_op, if0.reg_dst, if0.mem_to_reg, if0.pc_src,
                 if0.instr_done, if0.illegal};
            total++;
            if (a !== x || if1.state !== h) begin
               bad++;
               $display("FAIL %s: got outputs=%h halt_state=%0d, want outputs=%h halt_state=%0d",
                        n, a, if1.state, x, h);
            end
         end
      end
   end

   initial begin
      total      = 0;
      bad        = 0;
      halted     = 1'b0;
      reset      = 1'b1;
      if0.opcode = 6'h00;
      if0.funct  = 6'h00;
      if0.zero   = 1'b0;
      //          st pcw irw rw mw iod sa sb aop eop rd m2r ps dn il
      E_I    = e(0,  0,  0,  0, 0, 0,  0, 0, 0,  0,  0, 0,  0, 0, 0);
      E_F    = e(1,  1,  1,  0, 0, 0,  0, 1, 0,  0,  0, 0,  0, 0, 0);
      E_D    = e(2,  0,  0,  0, 0, 0,  0, 3, 0,  0,  0, 0,  0, 0, 0);
      E_DI   = e(2,  0,  0,  0, 0, 0,  0, 3, 0,  0,  0, 0,  0, 0, 1);
      E_XADD = e(7,  0,  0,  0, 0, 0,  1, 0, 0,  0,  0, 0,  0, 0, 0);
      E_XSUB = e(7,  0,  0,  0, 0, 0,  1, 0, 1,  0,  0, 0,  0, 0, 0);
      E_WBR  = e(8,  0,  0,  1, 0, 0,  0, 0, 0,  0,  1, 0,  0, 1, 0);
      E_MA   = e(3,  0,  0,  0, 0, 0,  1, 2, 0,  0,  0, 0,  0, 0, 0);
      E_MR   = e(4,  0,  0,  0, 0, 1,  0, 0, 0,  0,  0, 0,  0, 0, 0);
      E_MWB  = e(5,  0,  0,  1, 0, 0,  0, 0, 0,  0,  0, 1,  0, 1, 0);
      E_MWR  = e(6,  0,  0,  0, 1, 1,  0, 0, 0,  0,  0, 0,  0, 1, 0);
      E_XORI = e(9,  0,  0,  0, 0, 0,  1, 2, 2,  1,  0, 0,  0, 0, 0);
      E_XLUI = e(9,  0,  0,  0, 0, 0,  1, 2, 2,  2,  0, 0,  0, 0, 0);
      E_WBI  = e(10, 0,  0,  1, 0, 0,  0, 0, 0,  0,  0, 0,  0, 1, 0);
      E_BRT  = e(11, 1,  0,  0, 0, 0,  1, 0, 1,  0,  0, 0,  1, 1, 0);
      E_BRN  = e(11, 0,  0,  0, 0, 0,  1, 0, 1,  0,  0, 0,  1, 1, 0);
      E_J    = e(12, 1,  0,  0, 0, 0,  0, 0, 0,  0,  0, 0,  2, 1, 0);
      E_JAL  = e(12, 1,  0,  1, 0, 0,  0, 0, 0,  0,  2, 2,  2, 1, 0);
      E_JR   = e(12, 1,  0,  0, 0, 0,  0, 0, 0,  0,  0, 0,  3, 1, 0);

      for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 6'h00, 6'h21, 1'b0, E_I);
      step("reset_release", 1'b0, 6'h00, 6'h21, 1'b0, E_I);
      ins("addu", 6'h00, 6'h21, 1'b1, 2, E_XADD, E_WBR, E_I);
      ins("subu", 6'h00, 6'h23, 1'b0, 2, E_XSUB, E_WBR, E_I);
      ins("lw",   6'h23, 6'h00, 1'b1, 3, E_MA, E_MR, E_MWB);
      ins("ori",  6'h0D, 6'h00, 1'b0, 2, E_XORI, E_WBI, E_I);
      ins("lui",  6'h0F, 6'h00, 1'b0, 2, E_XLUI, E_WBI, E_I);
      ins("beq_taken", 6'h04, 6'h00, 1'b1, 1, E_BRT, E_I, E_I);
      step("beqn_fetch", 1'b0, 6'h04, 6'h00, 1'b1, E_F);
      step("beqn_decode", 1'b0, 6'h04, 6'h00, 1'b1, E_D);
      step("beqn_branch", 1'b0, 6'h04, 6'h00, 1'b0, E_BRN);
      ins("j",    6'h02, 6'h00, 1'b0, 1, E_J, E_I, E_I);
      ins("jal",  6'h03, 6'h00, 1'b0, 1, E_JAL, E_I, E_I);
      ins("jr",   6'h00, 6'h08, 1'b0, 1, E_JR, E_I, E_I);
      step("ill_fetch", 1'b0, 6'h3F, 6'h00, 1'b0, E_F);
      step("ill_decode", 1'b0, 6'h3F, 6'h00, 1'b0, E_DI);
      halted = 1'b1;
      ins("sw",   6'h2B, 6'h00, 1'b0, 2, E_MA, E_MWR, E_I);

      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      total += 2;
      if (if0.mem_wr !== 1'b0) begin
         bad++;
         $display("FAIL reset_async_mem_wr: got %b want 0", if0.mem_wr);
      end
      if (if0.state !== 4'd0) begin
         bad++;
         $display("FAIL reset_async_state: got %0d want 0", if0.state);
      end
      step("reset2_hold", 1'b1, 6'h2B, 6'h00, 1'b0, E_I);
      step("reset2_hold", 1'b1, 6'h2B, 6'h00, 1'b0, E_I);
      step("reset2_release", 1'b0, 6'h00, 6'h21, 1'b0, E_I);
      step("reset2_fetch", 1'b0, 6'h00, 6'h21, 1'b0, E_F);

      for (int i = 0; i < 4 && q_e.size() != 0; i++) @(negedge clk);
      #1;
      if (q_e.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", q_e.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
